// File: rtl/relay_scheduler_pkg.sv
// relay_scheduler_pkg: shared mode codes, owner encodings and scheduler states
package relay_scheduler_pkg;
  localparam logic [2:0] FAKE_READER = 3'b101;
  localparam logic [2:0] FAKE_TAG = 3'b110;
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_RDR = 2'b01;
  localparam logic [1:0] OWNER_TAG = 2'b10;
  typedef enum logic [1:0] {IDLE, GRANT_RDR, GRANT_TAG, FLUSH} state_e;
  function automatic logic mode_enabled(input logic [2:0] m);
    return m == FAKE_READER || m == FAKE_TAG;
  endfunction
endpackage

// File: rtl/relay_nibble_fifo.sv
// relay_nibble_fifo: nibble FIFO with flush and a look-ahead full flag for registered ready
module relay_nibble_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty,
  output logic       full_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3:0] mem_q [DEPTH];
  logic [3:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign full_next = cnt_d == CW'(DEPTH);
  assign dout = mem_q[rd_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok = pop && !empty && !flush;
  always_comb begin
    mem_d = mem_q;
    wr_d = flush ? '0 : wr_q + AW'(push_ok);
    rd_d = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) mem_d[wr_q] = din;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/relay_scheduler.sv
// relay_scheduler: slot-based arbiter issuing one buffered reader/tag nibble per slot to the relay datapath
module relay_scheduler
  import relay_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_CYCLES = 64,
  parameter int IDLE_SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] hi_simulate_mod_type,
  input  logic [3:0] rdr_nibble,
  input  logic       rdr_valid,
  output logic       rdr_ready,
  input  logic [3:0] tag_nibble,
  input  logic       tag_valid,
  output logic       tag_ready,
  output logic [3:0] data_in,
  output logic       data_in_available,
  output logic [1:0] owner,
  output logic       overflow,
  output logic       idle_timeout
);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(IDLE_SLOTS + 1);
  state_e state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic [2:0] mode_q, mode_d;
  logic [3:0] data_q, data_d, r_head, t_head;
  logic seen_q, seen_d, last_tag_q, last_tag_d;
  logic avail_q, avail_d, timeout_q, timeout_d, ovf_q, ovf_d;
  logic rrdy_q, rrdy_d, trdy_q, trdy_d;
  logic ok, change, flush, boundary, pop_r, pop_t;
  logic r_full, r_empty, r_full_next, t_full, t_empty, t_full_next;
  assign ok = mode_enabled(hi_simulate_mod_type);
  assign change = seen_q && hi_simulate_mod_type != mode_q;
  assign flush = change || state_q == FLUSH;
  assign boundary = slot_q == '0;
  assign idle_inc = idle_q + 1'b1;
  relay_nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_rdr_fifo (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(rdr_valid && rrdy_q), .pop(pop_r),
    .din(rdr_nibble), .dout(r_head), .full(r_full), .empty(r_empty), .full_next(r_full_next)
  );
  relay_nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(tag_valid && trdy_q), .pop(pop_t),
    .din(tag_nibble), .dout(t_head), .full(t_full), .empty(t_empty), .full_next(t_full_next)
  );
  always_comb begin
    state_d = state_q;
    idle_d = idle_q;
    last_tag_d = last_tag_q;
    timeout_d = 1'b0;
    pop_r = 1'b0;
    pop_t = 1'b0;
    if (change) begin
      state_d = FLUSH;
      idle_d = '0;
    end else begin
      case (state_q)
        IDLE: if (ok && boundary && !(r_empty && t_empty)) begin
          pop_r = !r_empty && (t_empty || last_tag_q);
          pop_t = !pop_r;
          state_d = pop_r ? GRANT_RDR : GRANT_TAG;
          last_tag_d = pop_t;
          idle_d = '0;
        end
        GRANT_RDR, GRANT_TAG: if (boundary) begin
          pop_r = state_q == GRANT_RDR && !r_empty;
          pop_t = state_q == GRANT_TAG && !t_empty;
          timeout_d = !(pop_r || pop_t) && idle_inc == IW'(IDLE_SLOTS);
          idle_d = (pop_r || pop_t || timeout_d) ? '0 : idle_inc;
          state_d = timeout_d ? IDLE : state_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    slot_d = slot_q + 1'b1;
    mode_d = hi_simulate_mod_type;
    seen_d = 1'b1;
    ovf_d = !flush && (ovf_q || (ok && ((rdr_valid && r_full) || (tag_valid && t_full))));
    rrdy_d = ok && !change && !r_full_next;
    trdy_d = ok && !change && !t_full_next;
    avail_d = pop_r || pop_t;
    data_d = pop_r ? r_head : pop_t ? t_head : data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q <= '0;
      idle_q <= '0;
      mode_q <= '0;
      seen_q <= 1'b0;
      last_tag_q <= 1'b1;
      data_q <= '0;
      avail_q <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q <= 1'b0;
      rrdy_q <= 1'b0;
      trdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      idle_q <= idle_d;
      mode_q <= mode_d;
      seen_q <= seen_d;
      last_tag_q <= last_tag_d;
      data_q <= data_d;
      avail_q <= avail_d;
      timeout_q <= timeout_d;
      ovf_q <= ovf_d;
      rrdy_q <= rrdy_d;
      trdy_q <= trdy_d;
    end
  end
  assign rdr_ready = rrdy_q;
  assign tag_ready = trdy_q;
  assign data_in = data_q;
  assign data_in_available = avail_q;
  assign overflow = ovf_q;
  assign idle_timeout = timeout_q;
  assign owner = state_q == GRANT_RDR ? OWNER_RDR : state_q == GRANT_TAG ? OWNER_TAG : OWNER_NONE;
endmodule
